// File: rtl/poly_pkg.sv
// rtl/poly_pkg.sv - shared width, FSM states and datapath select encodings for poly_eval_unit
package poly_pkg;

    localparam int WIDTH = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        MUL_B = 3'd2,
        MUL_C = 3'd3,
        STORE = 3'd4
    } state_t;

    // H input select: seed with A, or take one Horner step with B or C
    typedef enum logic [1:0] {
        HSEL_A     = 2'd0,
        HSEL_MAC_B = 2'd1,
        HSEL_MAC_C = 2'd2
    } hsel_t;

    typedef enum logic {
        CSEL_B = 1'b0,
        CSEL_C = 1'b1
    } csel_t;

endpackage

// File: rtl/poly_datapath.sv
// rtl/poly_datapath.sv - X/H/S registers and Horner multiply-add; POLY_SAT_EN clamps each step
module poly_datapath
    import poly_pkg::*;
#(
    parameter int W = WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         lx,
    input  logic         lh,
    input  logic         ls,
    input  hsel_t        h_sel,
    input  csel_t        c_sel,
    input  logic [W-1:0] x,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    output logic [W-1:0] s_q
);

    logic [W-1:0] x_q;
    logic [W-1:0] h_q;
    logic [W-1:0] coef;
    logic [W-1:0] mac;
    logic [W-1:0] h_next;

    assign coef = (c_sel == CSEL_C) ? c : b;

`ifdef POLY_SAT_EN
    logic [2*W-1:0] prod;
    logic [2*W:0]   sum;

    assign prod = {{W{1'b0}}, h_q} * {{W{1'b0}}, x_q};
    assign sum  = {1'b0, prod} + {{(W + 1){1'b0}}, coef};
    assign mac  = (|sum[2*W:W]) ? {W{1'b1}} : sum[W-1:0];
`else
    // Only the low W bits survive, so the narrow multiply-add is exact modulo 2^W
    assign mac = h_q * x_q + coef;
`endif

    assign h_next = (h_sel == HSEL_A) ? a : mac;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_q <= '0;
            h_q <= '0;
            s_q <= '0;
        end else begin
            if (lx) x_q <= x;
            if (lh) h_q <= h_next;
            if (ls) s_q <= h_q;
        end
    end

endmodule

// File: rtl/poly_eval_unit.sv
// rtl/poly_eval_unit.sv - multi-cycle A*x^2+B*x+C evaluator (Horner); option macro POLY_SAT_EN
module poly_eval_unit
    import poly_pkg::*;
#(
    parameter int WIDTH = poly_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inicio,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] C,
    output logic [WIDTH-1:0] resultado,
    output logic             pronto
);

    state_t state;
    logic   lx;
    logic   lh;
    logic   ls;
    hsel_t  h_sel;
    csel_t  c_sel;

    // Controls are registered for the state being entered, so they are valid throughout it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            lx     <= 1'b0;
            lh     <= 1'b0;
            ls     <= 1'b0;
            pronto <= 1'b0;
            h_sel  <= HSEL_A;
            c_sel  <= CSEL_B;
        end else begin
            lx     <= 1'b0;
            lh     <= 1'b0;
            ls     <= 1'b0;
            pronto <= 1'b0;
            case (state)
                IDLE: begin
                    if (inicio) begin
                        state <= LOAD;
                        lx    <= 1'b1;
                        lh    <= 1'b1;
                        h_sel <= HSEL_A;
                    end
                end
                LOAD: begin
                    state <= MUL_B;
                    lh    <= 1'b1;
                    h_sel <= HSEL_MAC_B;
                    c_sel <= CSEL_B;
                end
                MUL_B: begin
                    state <= MUL_C;
                    lh    <= 1'b1;
                    h_sel <= HSEL_MAC_C;
                    c_sel <= CSEL_C;
                end
                MUL_C: begin
                    state <= STORE;
                    ls    <= 1'b1;
                end
                STORE: begin
                    state  <= IDLE;
                    pronto <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    poly_datapath #(
        .W(WIDTH)
    ) u_datapath (
        .clk   (clk),
        .rst   (rst),
        .lx    (lx),
        .lh    (lh),
        .ls    (ls),
        .h_sel (h_sel),
        .c_sel (c_sel),
        .x     (x),
        .a     (A),
        .b     (B),
        .c     (C),
        .s_q   (resultado)
    );

endmodule

// File: tb/tb_poly_eval_unit.sv
// tb/tb_poly_eval_unit.sv - scoreboard bench for poly_eval_unit (wrap or POLY_SAT_EN build)
module tb_poly_eval_unit;

    localparam int W = 16;

    typedef struct {
        logic [W-1:0] value;
        int           cycle;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         inicio = 1'b0;
    logic [W-1:0] x = '0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic [W-1:0] C = '0;
    logic [W-1:0] resultado;
    logic         pronto;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb[$];

    poly_eval_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .inicio    (inicio),
        .x         (x),
        .A         (A),
        .B         (B),
        .C         (C),
        .resultado (resultado),
        .pronto    (pronto)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Monitor: every pronto pulse must match the oldest expected result and its edge
    always @(negedge clk) begin
        if (pronto === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_pronto", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("resultado", resultado, e.value);
                check("pronto_edge", cyc, e.cycle);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called at #1 after an edge with the unit idle: next edge is k, result at k+4
    task automatic run(input logic [W-1:0] xv, av, bv, cv, ev);
        exp_t e;
        x = xv; A = av; B = bv; C = cv;
        inicio = 1'b1;
        e.value = ev;
        e.cycle = cyc + 5;
        sb.push_back(e);
        tick(1);
        inicio = 1'b0;
        tick(6);
    endtask

    initial begin
        exp_t e;
        int k;

        #1 rst = 1'b0;
        #1;
        check("reset_resultado", resultado, 0);
        check("reset_pronto", pronto, 0);
        tick(2);
        rst = 1'b1;
        tick(20);
        check("idle_resultado", resultado, 0);
        check("idle_pronto", pronto, 0);

        run(16'd3, 16'd1, 16'd1, 16'd2, 16'd14);
        run(16'd0, 16'd5, 16'd7, 16'd9, 16'd9);
        run(16'd2, 16'd3, 16'd4, 16'd5, 16'd25);
        check("hold_between_runs", resultado, 25);
`ifdef POLY_SAT_EN
        run(16'h0100, 16'd1, 16'd0, 16'd0, 16'hFFFF);
        run(16'd2, 16'h4000, 16'd0, 16'd1, 16'hFFFF);
`else
        run(16'h0100, 16'd1, 16'd0, 16'd0, 16'h0000);
        run(16'd2, 16'h4000, 16'd0, 16'd1, 16'h0001);
`endif

        // inicio held: two back-to-back passes, x changed during the first MUL_C
        x = 16'd3; A = 16'd1; B = 16'd1; C = 16'd2;
        inicio = 1'b1;
        k = cyc + 1;
        e.value = 16'd14; e.cycle = k + 4;  sb.push_back(e);
        e.value = 16'd8;  e.cycle = k + 9;  sb.push_back(e);
        tick(3);
        x = 16'd2;
        tick(3);
        inicio = 1'b0;
        tick(8);
        check("sb_drained_after_hold", sb.size(), 0);

        // reset during MUL_B discards the run
        x = 16'd3; A = 16'd1; B = 16'd1; C = 16'd2;
        inicio = 1'b1;
        tick(2);
        #2 rst = 1'b0;
        #1;
        check("midrun_reset_resultado", resultado, 0);
        check("midrun_reset_pronto", pronto, 0);
        tick(2);
        rst = 1'b1;
        e.value = 16'd14; e.cycle = cyc + 5; sb.push_back(e);
        tick(1);
        inicio = 1'b0;
        tick(10);

        check("sb_drained_final", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/poly_eval_unit.md
Name: poly_eval_unit

Overview:
- Multi-cycle unsigned quadratic evaluator: resultado = A*x^2 + B*x + C, computed by Horner's method (H = A; H = H*x + B; H = H*x + C).
- Structure: a control FSM drives a datapath of registers, a multiplier/adder and operand muxes.
- The datapath has an X register, an H accumulator and an S result register.
- Standalone arithmetic block, started by the level signal inicio.

Parameters:
- WIDTH, 16, bit width of x, A, B, C, the internal registers and resultado.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  reset, asynchronous, active-low; clears all state.
- inicio  input  1  start request, level-sensitive, sampled only in IDLE.
- x  input  WIDTH  evaluation point, unsigned.
- A  input  WIDTH  x^2 coefficient, unsigned.
- B  input  WIDTH  x coefficient, unsigned.
- C  input  WIDTH  constant term, unsigned.
- resultado  output  WIDTH  last completed result; registered (S).
- pronto  output  1  one-cycle pulse, high in the cycle after S loads.

Behaviour:
- Reset (rst low, asynchronous): state=IDLE; X=0, H=0, S=0; resultado=0, pronto=0.
- Reset dominates clk at every point, including mid-computation. The in-flight computation is discarded.
- FSM states: IDLE, LOAD, MUL_B, MUL_C, STORE. Moore-style control outputs.
- IDLE: if inicio=1, next is LOAD; otherwise stay in IDLE.
- LOAD: X<=x, H<=A; next MUL_B.
- MUL_B: H<=H*X+B; next MUL_C.
- MUL_C: H<=H*X+C; next STORE.
- STORE: S<=H, pronto<=1; next IDLE.
- pronto is cleared on every other edge.
- Latency: first edge seeing IDLE with inicio=1 is edge k. S is updated and pronto asserted at edge k+4.
- If inicio is held high, the block recomputes continuously with a period of 5 cycles.
- Operand sampling: x and A only in LOAD, B only in MUL_B, C only in MUL_C. Changes at other times do not affect the current result.
- resultado holds its value between STOREs.
- Arithmetic: unsigned. Product H*X is 2*WIDTH bits, then the coefficient is added. Result is truncated to the low WIDTH bits (wrap modulo 2^WIDTH) at each step.
- inicio has no effect outside IDLE; no abort other than rst.

Optional Feature:
- Macro: POLY_SAT_EN.
- With the macro: each Horner step (MUL_B, MUL_C) computes the full-precision value. A value above 2^WIDTH-1 is clamped to 2^WIDTH-1 (0xFFFF) before loading H.
- Without the macro: wrap-around truncation as above.
- Latency and handshake are identical in both builds.

Decomposition:
- Shared package poly_pkg holds:
  - WIDTH default;
  - state enum (IDLE, LOAD, MUL_B, MUL_C, STORE);
  - mux select encodings for H input (A / H*X+B / H*X+C) and coefficient select (B / C).
- One sub-module is natural: poly_datapath. It contains X, H and S, the multiply-add and the muxes, driven by control lines LX, LH, LS and the selects.
- The FSM lives in the top (poly_eval_unit).

Test Plan:
1. rst low then high, inicio=0 -> resultado=0, pronto=0, stays idle indefinitely.
2. rst deasserted; x=3, A=1, B=1, C=2; inicio=1 -> resultado=14 and pronto=1 at edge k+4.
3. x=0, A=5, B=7, C=9, start -> resultado=9; then x=2, A=3, B=4, C=5 -> resultado=25.
4. x=0x0100, A=1, B=0, C=0 -> wrap build gives resultado=0x0000. POLY_SAT_EN build gives 0xFFFF.
5. inicio held high; x=3, A=B=1, C=2 gives 14. Change x to 2 while in MUL_C; next pass gives 8, with pronto pulses 5 cycles apart.
6. Start with x=3, A=B=1, C=2; pull rst low during MUL_B -> resultado=0 and pronto=0 immediately. After release with inicio=1, a fresh run yields 14.
